// File: rtl/spi_slave_if.sv
// Bus bundle for spi_slave: transmit/receive handshake plus the raw SPI pins.
// The slave modport is the design's view; the master modport is the driving side.
interface spi_slave_if #(
   parameter int Tran_width = 32
);
   logic                  i_SPI_Send_Sync;
   logic [Tran_width-1:0] i_SPI_Send_Data;
   logic                  o_SPI_Send_Over_ack;
   logic                  o_SPI_Receive_Sync;
   logic [Tran_width-1:0] o_SPI_Receive_Data;
   logic                  o_SPI_Frame_Err;
   logic                  i_SPI_Clk;
   logic                  i_SPI_SS;
   logic                  i_SPI_MOSI;
   logic                  o_SPI_MISO;
   logic                  o_SPI_MISO_En;

   modport slave (
      input  i_SPI_Send_Sync, i_SPI_Send_Data, i_SPI_Clk, i_SPI_SS, i_SPI_MOSI,
      output o_SPI_Send_Over_ack, o_SPI_Receive_Sync, o_SPI_Receive_Data,
      output o_SPI_Frame_Err, o_SPI_MISO, o_SPI_MISO_En
   );

   modport master (
      output i_SPI_Send_Sync, i_SPI_Send_Data, i_SPI_Clk, i_SPI_SS, i_SPI_MOSI,
      input  o_SPI_Send_Over_ack, o_SPI_Receive_Sync, o_SPI_Receive_Data,
      input  o_SPI_Frame_Err, o_SPI_MISO, o_SPI_MISO_En
   );
endinterface

// File: rtl/spi_slave.sv
// Oversampled SPI slave: all SPI pins are synchronized into c_clk_100m and
// edges are detected there, so SCLK must stay at or below c_clk_100m/8.
module spi_slave #(
   parameter int IDLE_VALUE_for_Clk    = 0,
   parameter int IDLE_VALUE_for_MISO   = 0,
   parameter int DATA_VALID_at_FALLING = 0,
   parameter int Tran_width            = 32,
   parameter int DE_GLITCH_Enable      = 0
) (
   input  logic        c_clk_100m,
   input  logic        i_rst_n,
   spi_slave_if.slave  bus
);
   localparam int W  = Tran_width;
   localparam int CW = $clog2(W + 1);
   localparam logic            L_CLK_IDLE  = (IDLE_VALUE_for_Clk != 0);
   localparam logic            L_MISO_IDLE = (IDLE_VALUE_for_MISO != 0);
   localparam logic [2:0]      L_SYNC_RST  = {L_CLK_IDLE, 1'b1, 1'b0};
   localparam logic [CW-1:0]   L_CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0]   L_CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]   L_CNT_LAST  = CW'(W - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [2:0]      r_meta, r_sync, r_sync_d, r_flt;
   logic [2:0]      w_in;
   logic [2:0]      w_agree;
   logic [1:0]      r_prev;
   logic [2:0]      r_arm_cnt;
   logic            r_armed;
   logic            w_clk_rise, w_clk_fall, w_ss_rise, w_ss_fall;
   logic            w_sample, w_shift;
   logic            w_start, w_abort, w_last, w_do_sample, w_do_shift;
   logic [CW-1:0]   r_bit_cnt;
   logic [W-2:0]    r_tx_shift;
   logic [W-1:0]    r_rx_shift;
   logic [W-1:0]    r_tx_buf;
   logic            r_loaded, r_frame_loaded, r_fin;
   logic [W-1:0]    r_rx_data;
   logic            r_rx_sync, r_ack, r_frame_err, r_miso, r_miso_en;

   // Bit order in every pin vector is {SCLK, SS, MOSI}.
   assign w_agree = ~(r_sync ^ r_sync_d);
   assign w_in    = (DE_GLITCH_Enable != 0) ? r_flt : r_sync;

   // Pin synchronizers plus the two-sample stability filter.
   always_ff @(posedge c_clk_100m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta   <= L_SYNC_RST;
         r_sync   <= L_SYNC_RST;
         r_sync_d <= L_SYNC_RST;
         r_flt    <= L_SYNC_RST;
         r_prev   <= L_SYNC_RST[2:1];
      end else begin
         r_meta   <= {bus.i_SPI_Clk, bus.i_SPI_SS, bus.i_SPI_MOSI};
         r_sync   <= r_meta;
         r_sync_d <= r_sync;
         r_flt    <= (r_flt & ~w_agree) | (r_sync & w_agree);
         r_prev   <= w_in[2:1];
      end
   end

   assign w_clk_rise = w_in[2] & ~r_prev[1];
   assign w_clk_fall = ~w_in[2] & r_prev[1];
   assign w_ss_rise  = w_in[1] & ~r_prev[0];
   assign w_ss_fall  = ~w_in[1] & r_prev[0];
   assign w_sample   = (DATA_VALID_at_FALLING != 0) ? w_clk_fall : w_clk_rise;
   assign w_shift    = (DATA_VALID_at_FALLING != 0) ? w_clk_rise : w_clk_fall;

   // Arms frame detection only once SS has been seen high with the pipeline
   // flushed, so a reset released mid-frame waits for a fresh SS fall.
   always_ff @(posedge c_clk_100m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_arm_cnt <= 3'd0;
         r_armed   <= 1'b0;
      end else begin
         if (r_arm_cnt != 3'd7) begin
            r_arm_cnt <= r_arm_cnt + 3'd1;
         end
         if ((r_arm_cnt == 3'd7) && w_in[1]) begin
            r_armed <= 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge c_clk_100m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state; an SS rise outranks a coincident sample edge.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_abort     = 1'b0;
      w_last      = 1'b0;
      w_do_sample = 1'b0;
      w_do_shift  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_ss_fall && r_armed) begin
               w_state_nxt = ST_ACTIVE;
               w_start     = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (w_ss_rise) begin
               w_state_nxt = ST_IDLE;
               w_abort     = 1'b1;
            end else if (w_sample) begin
               w_do_sample = 1'b1;
               if (r_bit_cnt == L_CNT_LAST) begin
                  w_state_nxt = ST_DONE;
                  w_last      = 1'b1;
               end else begin
                  w_state_nxt = ST_ACTIVE;
               end
            end else if (w_shift && (r_bit_cnt != L_CNT_ZERO)) begin
               w_do_shift  = 1'b1;
               w_state_nxt = ST_ACTIVE;
            end else begin
               w_state_nxt = ST_ACTIVE;
            end
         end
         ST_DONE: begin
            if (w_ss_rise) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_DONE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Shift registers, TX buffer bookkeeping and registered outputs.
   always_ff @(posedge c_clk_100m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bit_cnt      <= L_CNT_ZERO;
         r_tx_shift     <= {(W-1){1'b0}};
         r_rx_shift     <= {W{1'b0}};
         r_tx_buf       <= {W{1'b0}};
         r_loaded       <= 1'b0;
         r_frame_loaded <= 1'b0;
         r_fin          <= 1'b0;
         r_rx_data      <= {W{1'b0}};
         r_rx_sync      <= 1'b0;
         r_ack          <= 1'b0;
         r_frame_err    <= 1'b0;
         r_miso         <= L_MISO_IDLE;
         r_miso_en      <= 1'b0;
      end else begin
         r_fin       <= w_last;
         r_rx_sync   <= r_fin;
         r_ack       <= r_fin & r_frame_loaded;
         r_frame_err <= w_abort;
         r_miso_en   <= r_armed & ~w_in[1];
         if (r_fin) begin
            r_rx_data <= r_rx_shift;
         end

         if (w_start) begin
            r_bit_cnt      <= L_CNT_ZERO;
            r_tx_shift     <= r_tx_buf[W-2:0];
            r_miso         <= r_tx_buf[W-1];
            r_frame_loaded <= r_loaded;
         end else if (w_do_sample) begin
            r_rx_shift <= {r_rx_shift[W-2:0], w_in[0]};
            r_bit_cnt  <= r_bit_cnt + L_CNT_ONE;
            if (w_last) begin
               r_miso <= L_MISO_IDLE;
            end
         end else if (w_do_shift) begin
            r_miso     <= r_tx_shift[W-2];
            r_tx_shift <= {r_tx_shift[W-3:0], 1'b0};
         end else if (r_state != ST_ACTIVE) begin
            r_miso <= L_MISO_IDLE;
         end

         // A fresh load always wins; an aborted frame hands its word back.
         if (bus.i_SPI_Send_Sync) begin
            r_tx_buf <= bus.i_SPI_Send_Data;
            r_loaded <= 1'b1;
         end else if (w_start) begin
            r_loaded <= 1'b0;
         end else if (w_abort) begin
            r_loaded <= r_loaded | r_frame_loaded;
         end else if (r_fin && !r_loaded) begin
            r_tx_buf <= {W{1'b0}};
         end
      end
   end

   assign bus.o_SPI_Send_Over_ack = r_ack;
   assign bus.o_SPI_Receive_Sync  = r_rx_sync;
   assign bus.o_SPI_Receive_Data  = r_rx_data;
   assign bus.o_SPI_Frame_Err     = r_frame_err;
   assign bus.o_SPI_MISO          = r_miso;
   assign bus.o_SPI_MISO_En       = r_miso_en;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: three instances (default, 24-bit sample-on-fall,
// de-glitch) driven by a behavioural SPI master with a receive scoreboard.
module tb_spi_slave;
   logic        clk;
   logic        rst_n;
   logic        sclk;
   logic        mosi;
   logic [2:0]  ss_n;
   logic [2:0]  send_sync;
   logic [31:0] send_data;

   int          checks;
   int          failures;
   int          ack_cnt [3];
   int          err_cnt [3];
   logic [33:0] exp_q [$];
   logic [33:0] got_q [$];

   typedef struct {
      bit          do_load;
      logic [31:0] tx;
      logic [31:0] mosi_w;
      logic [31:0] exp_miso;
      int          exp_ack;
   } vec_t;
   vec_t vecs [5];

   spi_slave_if #(.Tran_width(32)) if0 ();
   spi_slave_if #(.Tran_width(24)) if1 ();
   spi_slave_if #(.Tran_width(32)) if2 ();

   assign if0.i_SPI_Clk = sclk;  assign if0.i_SPI_MOSI = mosi;  assign if0.i_SPI_SS = ss_n[0];
   assign if1.i_SPI_Clk = sclk;  assign if1.i_SPI_MOSI = mosi;  assign if1.i_SPI_SS = ss_n[1];
   assign if2.i_SPI_Clk = sclk;  assign if2.i_SPI_MOSI = mosi;  assign if2.i_SPI_SS = ss_n[2];
   assign if0.i_SPI_Send_Sync = send_sync[0];  assign if0.i_SPI_Send_Data = send_data;
   assign if1.i_SPI_Send_Sync = send_sync[1];  assign if1.i_SPI_Send_Data = send_data[23:0];
   assign if2.i_SPI_Send_Sync = send_sync[2];  assign if2.i_SPI_Send_Data = send_data;

   spi_slave #(.IDLE_VALUE_for_Clk(0), .IDLE_VALUE_for_MISO(0), .DATA_VALID_at_FALLING(0),
               .Tran_width(32), .DE_GLITCH_Enable(0))
      u_dut0 (.c_clk_100m(clk), .i_rst_n(rst_n), .bus(if0));
   spi_slave #(.IDLE_VALUE_for_Clk(0), .IDLE_VALUE_for_MISO(0), .DATA_VALID_at_FALLING(1),
               .Tran_width(24), .DE_GLITCH_Enable(0))
      u_dut1 (.c_clk_100m(clk), .i_rst_n(rst_n), .bus(if1));
   spi_slave #(.IDLE_VALUE_for_Clk(0), .IDLE_VALUE_for_MISO(0), .DATA_VALID_at_FALLING(0),
               .Tran_width(32), .DE_GLITCH_Enable(1))
      u_dut2 (.c_clk_100m(clk), .i_rst_n(rst_n), .bus(if2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output monitor: collects received words and counts handshake pulses.
   always @(negedge clk) begin
      if (if0.o_SPI_Receive_Sync) got_q.push_back({2'd0, if0.o_SPI_Receive_Data});
      if (if1.o_SPI_Receive_Sync) got_q.push_back({2'd1, 8'h00, if1.o_SPI_Receive_Data});
      if (if2.o_SPI_Receive_Sync) got_q.push_back({2'd2, if2.o_SPI_Receive_Data});
      if (if0.o_SPI_Send_Over_ack) ack_cnt[0] <= ack_cnt[0] + 1;
      if (if1.o_SPI_Send_Over_ack) ack_cnt[1] <= ack_cnt[1] + 1;
      if (if2.o_SPI_Send_Over_ack) ack_cnt[2] <= ack_cnt[2] + 1;
      if (if0.o_SPI_Frame_Err) err_cnt[0] <= err_cnt[0] + 1;
      if (if1.o_SPI_Frame_Err) err_cnt[1] <= err_cnt[1] + 1;
      if (if2.o_SPI_Frame_Err) err_cnt[2] <= err_cnt[2] + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic get_miso(input int sel);
      case (sel)
         0:       return if0.o_SPI_MISO;
         1:       return if1.o_SPI_MISO;
         default: return if2.o_SPI_MISO;
      endcase
   endfunction

   function automatic logic get_en(input int sel);
      case (sel)
         0:       return if0.o_SPI_MISO_En;
         1:       return if1.o_SPI_MISO_En;
         default: return if2.o_SPI_MISO_En;
      endcase
   endfunction

   task automatic load(input int sel, input logic [31:0] d);
      @(negedge clk);
      send_data      = d;
      send_sync[sel] = 1'b1;
      @(negedge clk);
      send_sync[sel] = 1'b0;
   endtask

   // Pops every expected word against what the DUT produced, then
   // requires that no unexpected Receive_Sync occurred.
   task automatic drain();
      logic [33:0] e;
      logic [33:0] g;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx_missing: actual=none required=%0h", e);
         end else begin
            g = got_q.pop_front();
            chk("rx_word", g, e);
         end
      end
      chk("rx_extra_sync", got_q.size(), 0);
      got_q.delete();
   endtask

   // One SS-framed transfer; hp is the SCLK half period in time units.
   task automatic frame(input int sel, input logic [31:0] mosi_w, input int nbits,
                        input bit dvaf, input int hp, input int abort_after,
                        input int glitch_at, input int load_at, input logic [31:0] load_w,
                        input int rst_at, output logic [31:0] miso_w);
      miso_w   = 32'h0;
      ss_n[sel] = 1'b0;
      #100;
      for (int i = 0; i < nbits; i++) begin
         if (i == abort_after) break;
         if (dvaf) sclk = 1'b1;
         mosi = mosi_w[nbits-1-i];
         if (i == glitch_at) begin
            #20; sclk = ~sclk; #10; sclk = ~sclk; #(hp-30);
         end else if (i == load_at) begin
            send_data = load_w; send_sync[sel] = 1'b1; #10; send_sync[sel] = 1'b0; #(hp-10);
         end else if (i == rst_at) begin
            rst_n = 1'b0;
            #20;
            chk("rst_miso", if0.o_SPI_MISO, 1'b0);
            chk("rst_miso_en", if0.o_SPI_MISO_En, 1'b0);
            chk("rst_rx_sync", if0.o_SPI_Receive_Sync, 1'b0);
            chk("rst_ack", if0.o_SPI_Send_Over_ack, 1'b0);
            chk("rst_frame_err", if0.o_SPI_Frame_Err, 1'b0);
            chk("rst_rx_data", if0.o_SPI_Receive_Data, 32'h0);
            rst_n = 1'b1;
            #(hp-20);
         end else begin
            #(hp);
         end
         miso_w = {miso_w[30:0], get_miso(sel)};
         if ((i == 0) && (rst_at < 0)) chk("miso_en", get_en(sel), 1'b1);
         sclk = dvaf ? 1'b0 : 1'b1;
         #(hp);
         if (!dvaf) sclk = 1'b0;
      end
      #(2*hp);
      ss_n[sel] = 1'b1;
      #300;
   endtask

   initial begin
      logic [31:0] m;
      int          a0;
      int          e0;
      checks = 0; failures = 0;
      for (int k = 0; k < 3; k++) begin ack_cnt[k] = 0; err_cnt[k] = 0; end
      rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; ss_n = 3'b111;
      send_sync = 3'b000; send_data = 32'h0;

      vecs[0] = '{1'b1, 32'h5A5AC3C3, 32'hFFFFA5A5, 32'h5A5AC3C3, 1};
      vecs[1] = '{1'b0, 32'h00000000, 32'h00000001, 32'h00000000, 0};
      vecs[2] = '{1'b1, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1};
      vecs[3] = '{1'b1, 32'h80000001, 32'hDEADBEEF, 32'h80000001, 1};
      vecs[4] = '{1'b0, 32'h00000000, 32'h7E7E8181, 32'h00000000, 0};

      repeat (3) @(negedge clk);
      chk("reset_miso", if0.o_SPI_MISO, 1'b0);
      chk("reset_miso_en", if0.o_SPI_MISO_En, 1'b0);
      chk("reset_rx_sync", if0.o_SPI_Receive_Sync, 1'b0);
      chk("reset_rx_data", if0.o_SPI_Receive_Data, 32'h0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         if (vecs[v].do_load) load(0, vecs[v].tx);
         a0 = ack_cnt[0];
         exp_q.push_back({2'd0, vecs[v].mosi_w});
         frame(0, vecs[v].mosi_w, 32, 1'b0, 50, -1, -1, -1, 32'h0, -1, m);
         chk("vec_miso", m, vecs[v].exp_miso);
         chk("vec_ack", ack_cnt[0] - a0, vecs[v].exp_ack);
         drain();
         chk("vec_rx_hold", if0.o_SPI_Receive_Data, vecs[v].mosi_w);
      end

      // Two loads between frames: the second one is sent.
      load(0, 32'hAAAA0000);
      load(0, 32'h0000BBBB);
      exp_q.push_back({2'd0, 32'h12121212});
      frame(0, 32'h12121212, 32, 1'b0, 50, -1, -1, -1, 32'h0, -1, m);
      chk("double_load_miso", m, 32'h0000BBBB);
      drain();

      // Aborted frame keeps the TX word for the next full frame.
      load(0, 32'hC0FFEE11);
      e0 = err_cnt[0]; a0 = ack_cnt[0];
      frame(0, 32'hFFFFFFFF, 32, 1'b0, 50, 10, -1, -1, 32'h0, -1, m);
      chk("abort_err", err_cnt[0] - e0, 1);
      chk("abort_ack", ack_cnt[0] - a0, 0);
      drain();
      exp_q.push_back({2'd0, 32'h0F1E2D3C});
      frame(0, 32'h0F1E2D3C, 32, 1'b0, 50, -1, -1, -1, 32'h0, -1, m);
      chk("retained_miso", m, 32'hC0FFEE11);
      chk("retained_ack", ack_cnt[0] - a0, 1);
      drain();

      // Load during ACTIVE only affects the next frame.
      load(0, 32'h0F0F0F0F);
      exp_q.push_back({2'd0, 32'h11111111});
      frame(0, 32'h11111111, 32, 1'b0, 50, -1, -1, 5, 32'h12345678, -1, m);
      chk("midload_cur_miso", m, 32'h0F0F0F0F);
      exp_q.push_back({2'd0, 32'h22222222});
      frame(0, 32'h22222222, 32, 1'b0, 50, -1, -1, -1, 32'h0, -1, m);
      chk("midload_next_miso", m, 32'h12345678);
      drain();

      // 24-bit, sample on falling edge.
      load(1, 32'h003C5AF0);
      a0 = ack_cnt[1]; e0 = err_cnt[1];
      exp_q.push_back({2'd1, 32'h00A5A5A5});
      frame(1, 32'h00A5A5A5, 24, 1'b1, 50, -1, -1, -1, 32'h0, -1, m);
      chk("w24_miso", m, 32'h003C5AF0);
      chk("w24_ack", ack_cnt[1] - a0, 1);
      chk("w24_err", err_cnt[1] - e0, 0);
      drain();

      // De-glitch instance with a one-cycle SCLK spike mid-frame.
      load(2, 32'h89ABCDEF);
      exp_q.push_back({2'd2, 32'h13579BDF});
      frame(2, 32'h13579BDF, 32, 1'b0, 80, -1, 16, -1, 32'h0, -1, m);
      chk("glitch_miso", m, 32'h89ABCDEF);
      drain();

      // Reset mid-frame: no receive until a fresh SS-framed transfer.
      load(0, 32'h55555555);
      e0 = err_cnt[0];
      frame(0, 32'h2468ACE0, 32, 1'b0, 50, -1, -1, -1, 32'h0, 10, m);
      chk("rst_frame_err_cnt", err_cnt[0] - e0, 0);
      drain();
      a0 = ack_cnt[0];
      exp_q.push_back({2'd0, 32'hFEDCBA98});
      frame(0, 32'hFEDCBA98, 32, 1'b0, 50, -1, -1, -1, 32'h0, -1, m);
      chk("post_rst_miso", m, 32'h0);
      chk("post_rst_ack", ack_cnt[0] - a0, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: SPI_Slave

Interface
REQ-001 SHALL provide parameter IDLE_VALUE_for_Clk, default 0, meaning the SCLK level while SS is high (CPOL).
REQ-002 SHALL provide parameter IDLE_VALUE_for_MISO, default 0, meaning the MISO level while SS is high or the frame is done.
REQ-003 SHALL provide parameter DATA_VALID_at_FALLING, default 0, meaning: 0 samples MOSI on SCLK rise and shifts MISO on fall; 1 samples on fall and shifts on rise.
REQ-004 SHALL provide parameter Tran_width, default 32, range 8..32, meaning bits per frame.
REQ-005 SHALL provide parameter DE_GLITCH_Enable, default 0, meaning 1 requires 2 consecutive equal synchronized samples before any SPI input level change is accepted.
REQ-006 SHALL provide port c_clk_100m, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-007 SHALL provide port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL provide port i_SPI_Send_Sync, input, 1 bit: 1-cycle load strobe for the transmit word.
REQ-009 SHALL provide port i_SPI_Send_Data, input, Tran_width bits: the transmit word, MSB first.
REQ-010 SHALL provide port o_SPI_Send_Over_ack, output, 1 bit: 1-cycle pulse when the loaded word has been fully shifted out.
REQ-011 SHALL provide port o_SPI_Receive_Sync, output, 1 bit: 1-cycle pulse when o_SPI_Receive_Data is valid.
REQ-012 SHALL provide port o_SPI_Receive_Data, output, Tran_width bits: the last complete received word, held until the next one.
REQ-013 SHALL provide port o_SPI_Frame_Err, output, 1 bit: 1-cycle pulse on an aborted frame.
REQ-014 SHALL provide ports i_SPI_Clk, i_SPI_SS (active low) and i_SPI_MOSI, inputs, 1 bit each: asynchronous SPI bus inputs.
REQ-015 SHALL provide ports o_SPI_MISO, output, 1 bit: slave data out; and o_SPI_MISO_En, output, 1 bit: high while SS is low.

Function
REQ-016 SHALL pass i_SPI_Clk, i_SPI_SS and i_SPI_MOSI through 2-flop synchronizers, plus a 2-cycle stability filter when DE_GLITCH_Enable=1.
REQ-017 SHALL detect SCLK edges and SS edges from the synchronized signals only; SCLK is supported up to c_clk_100m/8.
REQ-018 SHALL implement the FSM states IDLE, ACTIVE and DONE.
REQ-019 SHALL move IDLE->ACTIVE on a synchronized SS fall: bit count cleared, shift-out register loaded from the TX buffer, o_SPI_MISO driven with bit [Tran_width-1] in the same cycle.
REQ-020 SHALL, in ACTIVE, shift synchronized MOSI into the RX shift register LSB-side on each sample edge, MSB first, and increment the bit count.
REQ-021 SHALL, in ACTIVE, advance the next MISO bit on each shift edge; the shift edge before the first sample edge (CPHA-style leading edge) is ignored.
REQ-022 SHALL, on the Tran_width-th sample edge, go ACTIVE->DONE and, 1 cycle later, update o_SPI_Receive_Data and pulse o_SPI_Receive_Sync.
REQ-023 SHALL pulse o_SPI_Send_Over_ack in the same cycle as o_SPI_Receive_Sync if a word was loaded, then clear the TX buffer to 0.
REQ-024 SHALL, in DONE, ignore further SCLK edges, drive o_SPI_MISO=IDLE_VALUE_for_MISO, and return to IDLE on a synchronized SS rise.
REQ-025 SHALL, on an SS rise in ACTIVE with bit count < Tran_width, return to IDLE, pulse o_SPI_Frame_Err, emit no Receive_Sync or Send_Over_ack, and keep the TX buffer.
REQ-026 SHALL capture i_SPI_Send_Data into the TX buffer on i_SPI_Send_Sync in any state; a load during ACTIVE or DONE applies to the next frame and the current frame is unaffected.
REQ-027 SHALL send the current TX buffer content (0 after a completed frame) when no new load has occurred.
REQ-028 SHALL let the 2nd load win when two loads occur between frames.
REQ-029 SHALL give the SS edge priority when an SS rise and a sample edge coincide in the same cycle.

Reset
REQ-030 SHALL, when i_rst_n=0, asynchronously set the FSM to IDLE and clear all registers to 0, including TX buffer, RX data and bit count.
REQ-031 SHALL hold, during reset, o_SPI_Send_Over_ack, o_SPI_Receive_Sync, o_SPI_Frame_Err and o_SPI_MISO_En at 0, o_SPI_MISO at IDLE_VALUE_for_MISO, and synchronizer SS flops at 1.
REQ-032 SHALL, after reset is released mid-frame with SS low, stay in IDLE until SS rises then falls again.

Verification
REQ-033 SHALL pass this bench case: with defaults, load 32'h5A5AC3C3, master sends 32'hFFFFA5A5 at 10 MHz -> Receive_Data=32'hFFFFA5A5, one Receive_Sync, one Send_Over_ack, and MISO bit sequence 32'h5A5AC3C3.
REQ-034 SHALL pass this bench case: with Tran_width=24 and DATA_VALID_at_FALLING=1, master sends 24'hA5A5A5 -> Receive_Data=24'hA5A5A5.
REQ-035 SHALL pass this bench case: SS rises after 10 of 32 bits -> Frame_Err pulse, no Receive_Sync, and the next full frame transmits the retained TX word.
REQ-036 SHALL pass this bench case: load during ACTIVE of 32'h12345678 -> current frame MISO unchanged and the next frame sends 32'h12345678.
REQ-037 SHALL pass this bench case: with DE_GLITCH_Enable=1, a 1-cycle SCLK glitch mid-frame -> no bit counted and the received word is correct.
REQ-038 SHALL pass this bench case: i_rst_n pulsed low mid-frame -> outputs reset immediately and no Receive_Sync until a new SS-framed transfer completes.
